// File: rtl/freq_meas_ctrl.sv
// Equal-precision frequency meter sequencer: requests a gate window, collects the counts
// and computes fx_cnt * CLK_FS / fs_cnt with a 64-step restoring divider.
module freq_meas_ctrl #(
  parameter logic [31:0] CLK_FS      = 32'd50_000_000,
  parameter logic [31:0] TIMEOUT_CYC = 32'd100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        meas_en,
  output logic        meas_start,
  input  logic        cnt_vld,
  input  logic [31:0] fs_cnt,
  input  logic [31:0] fx_cnt,
  output logic        busy,
  output logic [31:0] data_fx,
  output logic        data_vld,
  output logic        timeout,
  output logic        div_err,
  output logic        sat
);

  localparam int unsigned CW = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned IW = 6;
  localparam logic [CW-1:0] TMO_LAST  = TIMEOUT_CYC - 32'd1;
  localparam logic [IW-1:0] LAST_ITER = IW'(PW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_MUL,
    S_DIV
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   tmo_cnt, tmo_cnt_d;
  logic [CW-1:0]   fs_lat, fs_lat_d;
  logic [CW-1:0]   fx_lat, fx_lat_d;
  logic [PW-1:0]   dvd, dvd_d;
  logic [CW-1:0]   rem, rem_d;
  logic [IW-1:0]   iter, iter_d;
  logic            meas_start_d, busy_d, data_vld_d, timeout_d, div_err_d, sat_d;
  logic [CW-1:0]   data_fx_d;

  // One restoring step: dividend shifts out MSB-first while quotient bits shift in at the LSB.
  logic [CW:0]     rem_sh;
  logic [CW-1:0]   rem_sub;
  logic            q_bit;
  logic [PW-1:0]   quo;

  always_comb begin
    rem_sh  = {rem, dvd[PW-1]};
    q_bit   = (rem_sh >= {1'b0, fs_lat});
    rem_sub = rem_sh[CW-1:0] - fs_lat;
    quo     = {dvd[PW-2:0], q_bit};
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    tmo_cnt_d    = tmo_cnt;
    fs_lat_d     = fs_lat;
    fx_lat_d     = fx_lat;
    dvd_d        = dvd;
    rem_d        = rem;
    iter_d       = iter;
    data_vld_d   = 1'b0;
    data_fx_d    = data_fx;
    timeout_d    = timeout;
    div_err_d    = div_err;
    sat_d        = sat;

    case (state)
      S_IDLE: begin
        if (meas_en) state_d = S_START;
      end
      S_START: begin
        tmo_cnt_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        tmo_cnt_d = tmo_cnt + CW'(1);
        if (cnt_vld) begin
          fs_lat_d = fs_cnt;
          fx_lat_d = fx_cnt;
          state_d  = S_MUL;
        end else if (!meas_en) begin
          state_d = S_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          data_vld_d = 1'b1;
          data_fx_d  = '0;
          timeout_d  = 1'b1;
          div_err_d  = 1'b0;
          sat_d      = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_MUL: begin
        dvd_d  = PW'(fx_lat) * PW'(CLK_FS);
        rem_d  = '0;
        iter_d = '0;
        if (fs_lat == '0) begin
          data_vld_d = 1'b1;
          data_fx_d  = '0;
          timeout_d  = 1'b0;
          div_err_d  = 1'b1;
          sat_d      = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        dvd_d  = quo;
        rem_d  = q_bit ? rem_sub : rem_sh[CW-1:0];
        iter_d = iter + IW'(1);
        if (iter == LAST_ITER) begin
          data_vld_d = 1'b1;
          timeout_d  = 1'b0;
          div_err_d  = 1'b0;
          if (quo[PW-1:CW] != '0) begin
            data_fx_d = '1;
            sat_d     = 1'b1;
          end else begin
            data_fx_d = quo[CW-1:0];
            sat_d     = 1'b0;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // meas_start is the registered image of START, so it appears in the first WAIT cycle
    meas_start_d = (state == S_START);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tmo_cnt    <= '0;
      fs_lat     <= '0;
      fx_lat     <= '0;
      dvd        <= '0;
      rem        <= '0;
      iter       <= '0;
      meas_start <= 1'b0;
      busy       <= 1'b0;
      data_fx    <= '0;
      data_vld   <= 1'b0;
      timeout    <= 1'b0;
      div_err    <= 1'b0;
      sat        <= 1'b0;
    end else begin
      state      <= state_d;
      tmo_cnt    <= tmo_cnt_d;
      fs_lat     <= fs_lat_d;
      fx_lat     <= fx_lat_d;
      dvd        <= dvd_d;
      rem        <= rem_d;
      iter       <= iter_d;
      meas_start <= meas_start_d;
      busy       <= busy_d;
      data_fx    <= data_fx_d;
      data_vld   <= data_vld_d;
      timeout    <= timeout_d;
      div_err    <= div_err_d;
      sat        <= sat_d;
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Self-checking bench for freq_meas_ctrl: directed corners plus randomized traffic,
// all outputs compared every cycle against a transaction-level timing/arithmetic model.
module tb_freq_meas_ctrl;

  localparam logic [31:0] CLK_FS = 32'd50_000_000;
  localparam logic [31:0] TMO    = 32'd100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meas_en = 1'b0;
  logic        cnt_vld = 1'b0;
  logic [31:0] fs_cnt = '0;
  logic [31:0] fx_cnt = '0;
  logic        meas_start, busy, data_vld, timeout, div_err, sat;
  logic [31:0] data_fx;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  freq_meas_ctrl #(.CLK_FS(CLK_FS), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .meas_en    (meas_en),
    .meas_start (meas_start),
    .cnt_vld    (cnt_vld),
    .fs_cnt     (fs_cnt),
    .fx_cnt     (fx_cnt),
    .busy       (busy),
    .data_fx    (data_fx),
    .data_vld   (data_vld),
    .timeout    (timeout),
    .div_err    (div_err),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 start, 2 waiting for counts, 3 computing
  int          ph = 0;
  int          wcnt = 0;
  int          remain = 0;
  logic [31:0] m_fs = '0, m_fx = '0;
  logic [63:0] q = '0;
  logic        e_busy = 0, e_ms = 0, e_vld = 0, e_to = 0, e_de = 0, e_sat = 0;
  logic [31:0] e_fx = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ph = 0; e_busy = 0; e_ms = 0; e_vld = 0; e_fx = '0; e_to = 0; e_de = 0; e_sat = 0;
      end else begin
        e_vld = 0;
        e_ms  = 0;
        case (ph)
          0: if (meas_en) ph = 1;
          1: begin ph = 2; wcnt = 0; e_ms = 1; end
          2: begin
            wcnt++;
            if (cnt_vld) begin
              m_fs = fs_cnt; m_fx = fx_cnt;
              remain = (fs_cnt == 0) ? 1 : 65;
              ph = 3;
            end else if (!meas_en) begin
              ph = 0;
            end else if (wcnt == int'(TMO)) begin
              e_vld = 1; e_fx = '0; e_to = 1; e_de = 0; e_sat = 0; ph = 0;
            end
          end
          default: begin
            remain--;
            if (remain == 0) begin
              e_vld = 1; e_to = 0;
              if (m_fs == 0) begin
                e_fx = '0; e_de = 1; e_sat = 0;
              end else begin
                q = (64'(m_fx) * 64'(CLK_FS)) / 64'(m_fs);
                e_de = 0;
                e_sat = ((q >> 32) != 0);
                e_fx = e_sat ? 32'hFFFF_FFFF : q[31:0];
              end
              ph = 0;
            end
          end
        endcase
        e_busy = (ph != 0);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en)
      check("cycle_outputs",
            64'({busy, meas_start, data_vld, timeout, div_err, sat, data_fx}),
            64'({e_busy, e_ms, e_vld, e_to, e_de, e_sat, e_fx}));
  end

  task automatic wait_ms(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (meas_start) begin n = i; break; end
    end
    check("meas_start_seen", 64'(n != 0), 64'(1));
  endtask

  // gap < 0: never drive counts (latency counted from the meas_start cycle)
  task automatic measure(input string name, input logic [31:0] fs, input logic [31:0] fx,
                         input int gap, input int drop_at, input int exp_ms, input int exp_lat,
                         input logic [31:0] exp_fx, input logic [2:0] exp_flags);
    int n, k;
    wait_ms(300, n);
    if (exp_ms > 0) check({name, "_ms_gap"}, 64'(n), 64'(exp_ms));
    if (gap >= 0) begin
      repeat (gap) @(negedge clk);
      fs_cnt = fs; fx_cnt = fx; cnt_vld = 1'b1;
    end
    k = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      cnt_vld = 1'b0;
      if (i == drop_at) meas_en = 1'b0;
      if (data_vld) begin k = i; break; end
    end
    check({name, "_latency"}, 64'(k), 64'(exp_lat));
    check({name, "_data_fx"}, 64'(data_fx), 64'(exp_fx));
    check({name, "_flags"}, 64'({timeout, div_err, sat}), 64'(exp_flags));
  endtask

  int n, cnt, nres, pv, sel;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_outputs", 64'({busy, meas_start, data_vld, timeout, div_err, sat, data_fx}), 64'(0));
    #2 rst_n = 1'b1;

    // counts offered while idle must be ignored
    repeat (3) @(negedge clk);
    fs_cnt = 32'd1; fx_cnt = 32'd1; cnt_vld = 1'b1;
    @(negedge clk);
    cnt_vld = 1'b0;
    cnt = 0;
    repeat (70) begin @(negedge clk); if (data_vld || busy) cnt++; end
    check("idle_cnt_vld_ignored", 64'(cnt), 64'(0));

    meas_en = 1'b1;
    measure("nominal",     32'd50_000_000, 32'd1_000_000, 3, 0, 0, 66, 32'd1_000_000, 3'b000);
    measure("trunc_3_1",   32'd3, 32'd1, 0, 0, 2, 66, 32'd16_666_666, 3'b000);
    measure("trunc_7_2",   32'd7, 32'd2, 5, 0, 2, 66, 32'd14_285_714, 3'b000);
    measure("div_zero",    32'd0, 32'd5, 1, 0, 2, 2, 32'd0, 3'b010);
    measure("saturate",    32'd1, 32'hFFFF_FFFF, 2, 0, 2, 66, 32'hFFFF_FFFF, 3'b001);
    measure("below_sat",   32'd1, 32'd85, 0, 0, 2, 66, 32'd4_250_000_000, 3'b000);
    measure("timeout",     32'd0, 32'd0, -1, 0, 2, 100, 32'd0, 3'b100);
    measure("after_tmo",   32'd50_000_000, 32'd1_000_000, 4, 0, 2, 66, 32'd1_000_000, 3'b000);
    measure("tmo_race",    32'd50_000_000, 32'd2_000_000, 99, 0, 2, 66, 32'd2_000_000, 3'b000);

    // meas_en dropped while waiting for counts: abort without a result
    wait_ms(300, n);
    repeat (5) @(negedge clk);
    meas_en = 1'b0;
    cnt = 0;
    repeat (120) begin @(negedge clk); if (data_vld) cnt++; end
    check("wait_abort_no_vld", 64'(cnt), 64'(0));
    check("wait_abort_idle", 64'(busy), 64'(0));

    // meas_en dropped mid-division: result still delivered, then idle
    meas_en = 1'b1;
    measure("div_drop", 32'd50_000_000, 32'd3_000_000, 2, 20, 0, 66, 32'd3_000_000, 3'b000);
    cnt = 0;
    repeat (20) begin @(negedge clk); if (meas_start || busy) cnt++; end
    check("div_drop_stays_idle", 64'(cnt), 64'(0));

    // reset asserted at division iteration 30
    meas_en = 1'b1;
    wait_ms(300, n);
    fs_cnt = 32'd50_000_000; fx_cnt = 32'd1_000_000; cnt_vld = 1'b1;
    repeat (32) begin @(negedge clk); cnt_vld = 1'b0; end
    check("pre_reset_busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    meas_en = 1'b0;
    #1 check("reset_mid_div", 64'({busy, meas_start, data_vld, timeout, div_err, sat, data_fx}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (busy || meas_start || data_vld) cnt++; end
    check("post_reset_idle", 64'(cnt), 64'(0));
    meas_en = 1'b1;
    measure("post_reset", 32'd7, 32'd2, 1, 0, 0, 66, 32'd14_285_714, 3'b000);

    // randomized traffic: frequent counts first, then sparse counts to provoke timeouts
    nres = 0;
    for (int p = 0; p < 2; p++) begin
      pv = (p == 0) ? 12 : 130;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (data_vld) nres++;
        if ($urandom_range(0, 199) == 0) meas_en = ~meas_en;
        cnt_vld = ($urandom_range(0, pv - 1) == 0);
        sel = int'($urandom_range(0, 7));
        fs_cnt = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 10)) : $urandom();
        fx_cnt = (sel == 2) ? 32'hFFFF_FFFF : $urandom();
      end
    end
    @(negedge clk);
    cnt_vld = 1'b0;
    meas_en = 1'b0;
    repeat (150) @(negedge clk);
    check("random_results_seen", 64'(nres > 0), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
